// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(63,56) receive-side decoder.
package bch_pkg;

  localparam int N     = 63;
  localparam int K     = 56;
  localparam int PAR_W = 7;
  localparam int MSG_W = 32;

  // g(x) = x^7 + x^6 + x^2 + 1 with the x^7 term dropped
  localparam logic [PAR_W-1:0] G_LOW  = 7'b1000101;
  localparam logic [23:0]      PREFIX = 24'h555555;

  typedef enum logic [2:0] {
    IDLE,
    SYND,
    EVAL,
    SEARCH,
    DONE
  } state_t;

endpackage

// File: rtl/bch_decoder_if.sv
// Request/result bundle between the link receiver (master) and the BCH decoder (slave).
interface bch_decoder_if;
  import bch_pkg::*;

  logic             start;
  logic [N-1:0]     C;
  logic [MSG_W-1:0] m;
  logic             done;
  logic             busy;
  logic             corrected;
  logic             uncorrectable;
  logic [5:0]       err_pos;
  logic             prefix_err;

  modport master (
    output start, C,
    input  m, done, busy, corrected, uncorrectable, err_pos, prefix_err
  );

  modport slave (
    input  start, C,
    output m, done, busy, corrected, uncorrectable, err_pos, prefix_err
  );

endinterface

// File: rtl/bch_lfsr7.sv
// Galois LFSR over g(x): each enabled cycle r <= (r*x + din) mod g.
// clr has priority over load, load over en.
module bch_lfsr7
  import bch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [PAR_W-1:0] load_val,
  input  logic             en,
  input  logic             din,
  output logic [PAR_W-1:0] r
);

  // din enters at x^0 so the final state is the true remainder C(x) mod g
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (load) begin
      r <= load_val;
    end else if (en) begin
      r <= {r[PAR_W-2:0], din} ^ (r[PAR_W-1] ? G_LOW : '0);
    end
  end

endmodule

// File: rtl/bch_decoder.sv
// Serial BCH(63,56) SEC-DED decoder: 63-cycle syndrome, 1-cycle evaluation, <=63-cycle locator search.
// Result 65..128 cycles after start; start ignored while busy; prefix compare built only with BCH_DEC_PREFIX_CHECK_EN.
module bch_decoder
  import bch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  bch_decoder_if.slave  bus
);

  state_t           state;
  state_t           stateNxt;
  logic [N-1:0]     cw;
  logic [5:0]       k;
  logic [PAR_W-1:0] synd;
  logic [PAR_W-1:0] loc;
  logic             cwBit;

  logic             capture;
  logic             synEn;
  logic             locLoad;
  logic             locEn;
  logic             kClr;
  logic             kInc;
  logic             setCorr;
  logic             setUnc;
  logic             finish;

  logic             pendCorr;
  logic             pendUnc;
  logic [MSG_W-1:0] mQ;
  logic             doneQ;
  logic             corrQ;
  logic             uncQ;
  logic [5:0]       errPosQ;

  // Codeword is fed most-significant coefficient first
  assign cwBit = cw[6'd62 - k];

  bch_lfsr7 uRemainder (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (capture),
    .load     (1'b0),
    .load_val ('0),
    .en       (synEn),
    .din      (cwBit),
    .r        (synd)
  );

  bch_lfsr7 uLocator (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (capture),
    .load     (locLoad),
    .load_val (7'h01),
    .en       (locEn),
    .din      (1'b0),
    .r        (loc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    capture  = 1'b0;
    synEn    = 1'b0;
    locLoad  = 1'b0;
    locEn    = 1'b0;
    kClr     = 1'b0;
    kInc     = 1'b0;
    setCorr  = 1'b0;
    setUnc   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          stateNxt = SYND;
          capture  = 1'b1;
          kClr     = 1'b1;
        end
      end
      SYND: begin
        synEn = 1'b1;
        if (k == 6'd62) begin
          stateNxt = EVAL;
          kClr     = 1'b1;
        end else begin
          kInc = 1'b1;
        end
      end
      EVAL: begin
        if (synd == '0) begin
          stateNxt = DONE;
        end else if (~^synd) begin
          // Every single-bit syndrome has odd weight because (x+1) divides g
          stateNxt = DONE;
          setUnc   = 1'b1;
        end else begin
          stateNxt = SEARCH;
          locLoad  = 1'b1;
          kClr     = 1'b1;
        end
      end
      SEARCH: begin
        if (loc == synd) begin
          stateNxt = DONE;
          setCorr  = 1'b1;
        end else if (k == 6'd62) begin
          stateNxt = DONE;
          setUnc   = 1'b1;
        end else begin
          locEn = 1'b1;
          kInc  = 1'b1;
        end
      end
      DONE: begin
        stateNxt = IDLE;
        finish   = 1'b1;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw       <= '0;
      k        <= '0;
      pendCorr <= 1'b0;
      pendUnc  <= 1'b0;
      mQ       <= '0;
      doneQ    <= 1'b0;
      corrQ    <= 1'b0;
      uncQ     <= 1'b0;
      errPosQ  <= '0;
    end else begin
      doneQ <= finish;
      if (capture) begin
        cw       <= bus.C;
        pendCorr <= 1'b0;
        pendUnc  <= 1'b0;
        mQ       <= '0;
        corrQ    <= 1'b0;
        uncQ     <= 1'b0;
        errPosQ  <= '0;
      end
      if (kClr) begin
        k <= '0;
      end else if (kInc) begin
        k <= k + 6'd1;
      end
      if (setUnc) begin
        pendUnc <= 1'b1;
      end
      // k is frozen on a hit, so it still names the flipped bit in DONE
      if (setCorr) begin
        pendCorr <= 1'b1;
        cw[k]    <= ~cw[k];
      end
      if (finish) begin
        mQ      <= cw[MSG_W+PAR_W-1:PAR_W];
        corrQ   <= pendCorr;
        uncQ    <= pendUnc;
        errPosQ <= pendCorr ? k : 6'd0;
      end
    end
  end

`ifdef BCH_DEC_PREFIX_CHECK_EN
  logic prefixErrQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prefixErrQ <= 1'b0;
    end else if (capture) begin
      prefixErrQ <= 1'b0;
    end else if (finish) begin
      prefixErrQ <= (cw[N-1:MSG_W+PAR_W] != PREFIX);
    end
  end

  assign bus.prefix_err = prefixErrQ;
`else
  assign bus.prefix_err = 1'b0;
`endif

  assign bus.m             = mQ;
  assign bus.done          = doneQ;
  assign bus.busy          = (state != IDLE);
  assign bus.corrected     = corrQ;
  assign bus.uncorrectable = uncQ;
  assign bus.err_pos       = errPosQ;

endmodule

// File: tb/tb_bch_decoder.sv
// Directed bench for bch_decoder: clean, single, double, prefix and control-corner vectors.
module tb_bch_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [62:0] baseCw;

  bch_decoder_if dutIf ();

  bch_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dutIf)
  );

  always #5 clk = ~clk;

  // Systematic encoder: parity = data(x) * x^7 mod g(x)
  function automatic logic [62:0] encode(input logic [23:0] pre, input logic [31:0] msg);
    logic [55:0] d;
    logic [6:0]  r;
    logic        fb;
    d = {pre, msg};
    r = '0;
    for (int i = 55; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r  = {r[5:0], 1'b0} ^ (fb ? 7'b1000101 : 7'b0);
    end
    return {d, r};
  endfunction

  // Start at edge 0 and return the cycle in which done is seen (200 means it never came)
  task automatic run_decode(input logic [62:0] cw, output int cyc);
    @(negedge clk);
    dutIf.start = 1'b1;
    dutIf.C     = cw;
    @(posedge clk);
    #1 dutIf.start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (dutIf.done) break;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (dutIf.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", dutIf.done); end
    vectors++; if (dutIf.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", dutIf.busy); end
    vectors++; if ({dutIf.m, dutIf.corrected, dutIf.uncorrectable, dutIf.err_pos, dutIf.prefix_err} !== 41'd0) begin
      miscompares++; $display("FAIL reset_outputs: got m=%h c=%b u=%b pos=%0d p=%b want all 0",
        dutIf.m, dutIf.corrected, dutIf.uncorrectable, dutIf.err_pos, dutIf.prefix_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    int cyc;
    run_decode(baseCw, cyc);
    vectors++; if (cyc !== 65) begin miscompares++; $display("FAIL clean_cycle: got %0d want 65", cyc); end
    vectors++; if (dutIf.m !== 32'hDEADBEEF) begin miscompares++; $display("FAIL clean_m: got %h want DEADBEEF", dutIf.m); end
    vectors++; if (dutIf.corrected !== 1'b0 || dutIf.uncorrectable !== 1'b0) begin
      miscompares++; $display("FAIL clean_flags: got c=%b u=%b want 0 0", dutIf.corrected, dutIf.uncorrectable); end
    vectors++; if (dutIf.prefix_err !== 1'b0) begin miscompares++; $display("FAIL clean_prefix: got %b want 0", dutIf.prefix_err); end
    @(posedge clk); #1;
    vectors++; if (dutIf.done !== 1'b0 || dutIf.m !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL clean_hold: got done=%b m=%h want 0 DEADBEEF", dutIf.done, dutIf.m); end
  endtask

  task automatic test_single_error(input int bitIdx, input int expCyc);
    int cyc;
    logic [62:0] cw;
    cw = baseCw;
    cw[bitIdx] = ~cw[bitIdx];
    run_decode(cw, cyc);
    vectors++; if (cyc !== expCyc) begin miscompares++; $display("FAIL single%0d_cycle: got %0d want %0d", bitIdx, cyc, expCyc); end
    vectors++; if (dutIf.corrected !== 1'b1 || dutIf.uncorrectable !== 1'b0) begin
      miscompares++; $display("FAIL single%0d_flags: got c=%b u=%b want 1 0", bitIdx, dutIf.corrected, dutIf.uncorrectable); end
    vectors++; if (dutIf.err_pos !== 6'(bitIdx)) begin miscompares++; $display("FAIL single%0d_pos: got %0d want %0d", bitIdx, dutIf.err_pos, bitIdx); end
    vectors++; if (dutIf.m !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single%0d_m: got %h want DEADBEEF", bitIdx, dutIf.m); end
    vectors++; if (dutIf.prefix_err !== 1'b0) begin miscompares++; $display("FAIL single%0d_prefix: got %b want 0", bitIdx, dutIf.prefix_err); end
  endtask

  task automatic test_double_error();
    int cyc;
    logic [62:0] cw;
    cw = baseCw;
    cw[10] = ~cw[10];
    cw[20] = ~cw[20];
    run_decode(cw, cyc);
    vectors++; if (cyc !== 65) begin miscompares++; $display("FAIL double_cycle: got %0d want 65", cyc); end
    vectors++; if (dutIf.uncorrectable !== 1'b1 || dutIf.corrected !== 1'b0) begin
      miscompares++; $display("FAIL double_flags: got c=%b u=%b want 0 1", dutIf.corrected, dutIf.uncorrectable); end
    vectors++; if (dutIf.m !== 32'hDEAD9EE7) begin miscompares++; $display("FAIL double_m: got %h want DEAD9EE7", dutIf.m); end
    vectors++; if (dutIf.err_pos !== 6'd0) begin miscompares++; $display("FAIL double_pos: got %0d want 0", dutIf.err_pos); end
  endtask

  task automatic test_prefix();
    int cyc;
    logic expPre;
`ifdef BCH_DEC_PREFIX_CHECK_EN
    expPre = 1'b1;
`else
    expPre = 1'b0;
`endif
    run_decode(encode(24'h000000, 32'h12345678), cyc);
    vectors++; if (cyc !== 65) begin miscompares++; $display("FAIL prefix_cycle: got %0d want 65", cyc); end
    vectors++; if (dutIf.prefix_err !== expPre) begin miscompares++; $display("FAIL prefix_err: got %b want %b", dutIf.prefix_err, expPre); end
    vectors++; if (dutIf.corrected !== 1'b0 || dutIf.uncorrectable !== 1'b0 || dutIf.m !== 32'h12345678) begin
      miscompares++; $display("FAIL prefix_result: got c=%b u=%b m=%h want 0 0 12345678",
        dutIf.corrected, dutIf.uncorrectable, dutIf.m); end
  endtask

  task automatic test_reset_mid_search();
    int cyc;
    logic [62:0] cw;
    cw = baseCw;
    cw[62] = ~cw[62];
    @(negedge clk);
    dutIf.start = 1'b1;
    dutIf.C     = cw;
    @(posedge clk);
    #1 dutIf.start = 1'b0;
    repeat (90) @(posedge clk);
    #1;
    vectors++; if (dutIf.busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", dutIf.busy); end
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dutIf.busy !== 1'b0 || dutIf.done !== 1'b0) begin
      miscompares++; $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", dutIf.busy, dutIf.done); end
    vectors++; if ({dutIf.m, dutIf.corrected, dutIf.uncorrectable, dutIf.err_pos, dutIf.prefix_err} !== 41'd0) begin
      miscompares++; $display("FAIL midrst_outputs: got m=%h c=%b u=%b pos=%0d want all 0",
        dutIf.m, dutIf.corrected, dutIf.uncorrectable, dutIf.err_pos); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (dutIf.done !== 1'b0 || dutIf.busy !== 1'b0) begin
      miscompares++; $display("FAIL midrst_idle: got done=%b busy=%b want 0 0", dutIf.done, dutIf.busy); end
    run_decode(baseCw, cyc);
    vectors++; if (cyc !== 65 || dutIf.m !== 32'hDEADBEEF || dutIf.corrected !== 1'b0) begin
      miscompares++; $display("FAIL midrst_resume: got cyc=%0d m=%h c=%b want 65 DEADBEEF 0", cyc, dutIf.m, dutIf.corrected); end
  endtask

  task automatic test_start_while_busy();
    int cyc;
    logic [62:0] cw1;
    logic [62:0] cw2;
    cw1 = baseCw;
    cw1[20] = ~cw1[20];
    cw2 = baseCw;
    cw2[3] = ~cw2[3];
    cw2[40] = ~cw2[40];
    @(negedge clk);
    dutIf.start = 1'b1;
    dutIf.C     = cw1;
    @(posedge clk);
    #1 dutIf.start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (dutIf.done) break;
      if (cyc == 10) begin
        vectors++; if (dutIf.busy !== 1'b1) begin miscompares++; $display("FAIL busy_mid: got %b want 1", dutIf.busy); end
        dutIf.start = 1'b1;
        dutIf.C     = cw2;
      end else if (cyc == 11) begin
        dutIf.start = 1'b0;
      end
    end
    vectors++; if (cyc !== 86) begin miscompares++; $display("FAIL busy_cycle: got %0d want 86", cyc); end
    vectors++; if (dutIf.corrected !== 1'b1 || dutIf.uncorrectable !== 1'b0 || dutIf.err_pos !== 6'd20) begin
      miscompares++; $display("FAIL busy_result: got c=%b u=%b pos=%0d want 1 0 20",
        dutIf.corrected, dutIf.uncorrectable, dutIf.err_pos); end
    vectors++; if (dutIf.busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: got %b want 0", dutIf.busy); end
  endtask

  initial begin
    dutIf.start = 1'b0;
    dutIf.C     = '0;
    baseCw      = encode(24'h555555, 32'hDEADBEEF);
    test_reset();
    test_clean();
    test_single_error(0, 66);
    test_single_error(62, 128);
    test_single_error(20, 86);
    test_single_error(7, 73);
    test_double_error();
    test_prefix();
    test_reset_mid_search();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
